// File: rtl/vga_capture.sv
// Locks onto a synchronous VGA stream and down-samples the visible area into 8x8 9-bit tiles.
// Latency: we/WA/WV one cycle after the sample cycle; locked/frame_done one cycle after the sync edge.
// Backpressure: none, the stream is never stalled. Macro VGA_CAPTURE_ERRCNT_EN enables the error counter.
module vga_capture #(
    parameter int H_TOTAL      = 1041,
    parameter int V_TOTAL      = 667,
    parameter int H_ACTIVE_OFS = 184,
    parameter int H_ACTIVE     = 799,
    parameter int V_ACTIVE_OFS = 29,
    parameter int V_ACTIVE     = 599
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       h_sync,
    input  logic       v_sync,
    input  logic [3:0] r,
    input  logic [3:0] g,
    input  logic [3:0] b,
    output logic       we,
    output logic [5:0] WA,
    output logic [8:0] WV,
    output logic       locked,
    output logic       frame_done,
    output logic [7:0] err_cnt
);

    localparam logic [10:0] COL_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] LINE_LAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_OFS     = 11'(H_ACTIVE_OFS);
    localparam logic [10:0] V_OFS     = 11'(V_ACTIVE_OFS);
    localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
    localparam logic [10:0] TILE_SPAN = 11'd512;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        h_sync_q, v_sync_q;
    logic [10:0] col_q, col_d;
    logic [10:0] line_q, line_d;
    logic        skip_q, skip_d;
    logic        we_q, we_d;
    logic [5:0]  wa_q, wa_d;
    logic [8:0]  wv_q, wv_d;
    logic        locked_q, locked_d;
    logic        frame_done_q, frame_done_d;

    logic        h_rise, v_rise;
    logic [10:0] line_base;
    logic [10:0] px, py;
    logic        checking, line_fail, frame_fail, any_fail, sample;
    logic        unused_lsb;

    assign unused_lsb = ^{r[0], g[0], b[0]};

    always_comb begin
        h_rise = h_sync & ~h_sync_q;
        v_rise = v_sync & ~v_sync_q;

        // col_d/line_d are the coordinates of the current cycle; the _q copies hold the previous cycle.
        col_d     = h_rise ? 11'd0 : ((col_q == 11'h7FF) ? col_q : col_q + 11'd1);
        line_base = v_rise ? 11'h7FF : line_q;
        line_d    = h_rise ? line_base + 11'd1 : line_base;
        px        = col_d - H_OFS;
        py        = line_d - V_OFS;

        checking   = (state_q != IDLE);
        line_fail  = checking && h_rise && !skip_q && (col_q != COL_LAST);
        frame_fail = checking && v_rise && (line_q != LINE_LAST);
        any_fail   = line_fail || frame_fail;

        state_d = state_q;
        case (state_q)
            IDLE:    if (v_rise) state_d = MEASURE;
            MEASURE: begin
                if (any_fail)    state_d = IDLE;
                else if (v_rise) state_d = LOCKED;
            end
            LOCKED:  if (any_fail) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The column count before the first line start after acquisition is meaningless.
        if (state_q == IDLE && v_rise) skip_d = 1'b1;
        else if (h_rise)               skip_d = 1'b0;
        else                           skip_d = skip_q;

        sample = (state_q == LOCKED) && !any_fail
              && (col_d >= H_OFS) && (px < TILE_SPAN) && (px < H_ACT) && (px[5:0] == 6'd32)
              && (line_d >= V_OFS) && (py < TILE_SPAN) && (py < V_ACT) && (py[5:0] == 6'd32);

        we_d         = sample;
        wa_d         = sample ? {px[8:6], py[8:6]} : wa_q;
        wv_d         = sample ? {r[3:1], g[3:1], b[3:1]} : wv_q;
        locked_d     = (state_d == LOCKED);
        frame_done_d = v_rise && (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            h_sync_q     <= 1'b0;
            v_sync_q     <= 1'b0;
            col_q        <= 11'd0;
            line_q       <= 11'h7FF;
            skip_q       <= 1'b0;
            we_q         <= 1'b0;
            wa_q         <= 6'd0;
            wv_q         <= 9'd0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_sync_q     <= h_sync;
            v_sync_q     <= v_sync;
            col_q        <= col_d;
            line_q       <= line_d;
            skip_q       <= skip_d;
            we_q         <= we_d;
            wa_q         <= wa_d;
            wv_q         <= wv_d;
            locked_q     <= locked_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign we         = we_q;
    assign WA         = wa_q;
    assign WV         = wv_q;
    assign locked     = locked_q;
    assign frame_done = frame_done_q;

`ifdef VGA_CAPTURE_ERRCNT_EN
    logic [7:0] err_q, err_d;

    // A line and frame failure in the same cycle count as one event.
    always_comb begin
        err_d = (any_fail && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 8'd0;
        else        err_q <= err_d;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
